// File: rtl/clm_mixcol_ark_serial_pkg.sv
// Shared types for the column-serial masked MixColumns + AddRoundKey stage.
// A masked byte x is held as shares s0..s3 with x = L*s0 ^ s1 ^ s2 ^ s3.
package clm_mixcol_ark_serial_pkg;

   localparam int d            = 3;
   localparam int NUM_SHARES   = d + 1;
   localparam int NUM_COLS     = 4;
   localparam int NUM_ROWS     = 4;
   localparam int COL_BITS     = 8 * NUM_ROWS;
   localparam int RAND_PER_COL = 16;

   typedef logic [7:0]                  red_poly_t;
   typedef logic [NUM_SHARES-1:0][7:0]  state_t;
   typedef state_t      [0:NUM_ROWS-1]  state_word_t;
   typedef state_word_t [0:NUM_COLS-1]  state_mat_t;
   typedef red_poly_t   [0:RAND_PER_COL-1] rand_vect_t;

   // Row i of a matrix selects the input bits that XOR into output bit i.
   // Column vectors place bit k of row r at bit 8*r+k.
   typedef logic [7:0][7:0]                   mm_matrix_t;
   typedef logic [COL_BITS-1:0][COL_BITS-1:0] bm_matrix_t;
   typedef logic [COL_BITS-1:0][COL_BITS-1:0] mr_matrix_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mcark_state_t;

   function automatic red_poly_t mulByte(input mm_matrix_t m, input red_poly_t v);
      red_poly_t res;
      res = '0;
      for (int i = 0; i < 8; i++) res[i] = ^(m[i] & v);
      return res;
   endfunction

   function automatic logic [COL_BITS-1:0] mulCol(input mr_matrix_t m,
                                                 input logic [COL_BITS-1:0] v);
      logic [COL_BITS-1:0] res;
      res = '0;
      for (int i = 0; i < COL_BITS; i++) res[i] = ^(m[i] & v);
      return res;
   endfunction

endpackage

// File: rtl/clm_mixcol_ark_serial_mix.sv
// Masked MixColumns on a single column: share-wise GF(2) matrix multiply
// followed by a value-preserving refresh of every byte with four fresh words.
module mix_column_single
   import clm_mixcol_ark_serial_pkg::*;
(
   input  state_word_t col_i,
   input  rand_vect_t  rand_i,
   input  mm_matrix_t  L_i,
   input  bm_matrix_t  B_ext_MC_i,
   input  mr_matrix_t  MC_i,
   output state_word_t col_o
);

   logic [NUM_SHARES-1:0][COL_BITS-1:0] shareCol;
   logic [NUM_SHARES-1:0][COL_BITS-1:0] mixedCol;

   always_comb begin
      shareCol = '0;
      for (int s = 0; s < NUM_SHARES; s++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            shareCol[s][8*r +: 8] = col_i[r][s];
         end
      end
   end

   // Share 0 lives in the L-encoded domain, so it needs the conjugated matrix.
   always_comb begin
      mixedCol = '0;
      mixedCol[0] = mulCol(B_ext_MC_i, shareCol[0]);
      for (int s = 1; s < NUM_SHARES; s++) begin
         mixedCol[s] = mulCol(MC_i, shareCol[s]);
      end
   end

   // Every word enters two shares, weighted by L when paired with share 0,
   // so the decoded byte is untouched while all shares are re-randomised.
   always_comb begin
      col_o = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         col_o[r][0] = mixedCol[0][8*r +: 8] ^ rand_i[4*r] ^ rand_i[4*r+2];
         col_o[r][1] = mixedCol[1][8*r +: 8] ^ mulByte(L_i, rand_i[4*r]) ^ rand_i[4*r+1];
         col_o[r][2] = mixedCol[2][8*r +: 8] ^ rand_i[4*r+1] ^ rand_i[4*r+3]
                       ^ mulByte(L_i, rand_i[4*r+2]);
         col_o[r][3] = mixedCol[3][8*r +: 8] ^ rand_i[4*r+3];
      end
   end

endmodule

// File: rtl/clm_mixcol_ark_serial.sv
// Column-serial masked MixColumns + AddRoundKey: one column per consumed
// randomness set through a single mix_column_single instance.
module clm_mixcol_ark_serial
   import clm_mixcol_ark_serial_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  state_mat_t in_state,
   input  state_mat_t in_key,
   input  logic       rand_valid,
   output logic       rand_ready,
   input  rand_vect_t random_vect,
   input  mm_matrix_t L,
   input  bm_matrix_t B_ext_MC,
   input  mr_matrix_t MC,
   output logic       out_valid,
   input  logic       out_ready,
   output state_mat_t out_state
);

   localparam logic [1:0] LastCol = 2'(NUM_COLS - 1);

   mcark_state_t state_q, state_d;
   logic [1:0]   colCnt_q, colCnt_d;
   state_mat_t   stateReg_q, keyReg_q, resultReg_q;
   logic         idleReady, captureEn, colWriteEn;
   state_word_t  mixOut;

   mix_column_single uMix (
      .col_i      (stateReg_q[colCnt_q]),
      .rand_i     (random_vect),
      .L_i        (L),
      .B_ext_MC_i (B_ext_MC),
      .MC_i       (MC),
      .col_o      (mixOut)
   );

   always_comb begin
      state_d    = state_q;
      colCnt_d   = colCnt_q;
      idleReady  = 1'b0;
      rand_ready = 1'b0;
      out_valid  = 1'b0;
      captureEn  = 1'b0;
      colWriteEn = 1'b0;
      unique case (state_q)
         IDLE: begin
            idleReady = 1'b1;
            if (in_valid) begin
               captureEn = 1'b1;
               colCnt_d  = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            rand_ready = 1'b1;
            if (rand_valid) begin
               colWriteEn = 1'b1;
               colCnt_d   = colCnt_q + 2'd1;
               if (colCnt_q == LastCol) state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // While reset is held the stage must not advertise readiness.
   assign in_ready  = idleReady & rst_n;
   assign out_state = resultReg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         colCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         colCnt_q <= colCnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg_q  <= '0;
         keyReg_q    <= '0;
         resultReg_q <= '0;
      end else begin
         if (captureEn) begin
            stateReg_q <= in_state;
            keyReg_q   <= in_key;
         end
         if (colWriteEn) begin
            resultReg_q[colCnt_q] <= mixOut ^ keyReg_q[colCnt_q];
         end
      end
   end

endmodule

// File: tb/tb_clm_mixcol_ark_serial.sv
// Randomised bench for clm_mixcol_ark_serial against a byte-level AES
// MixColumns/AddRoundKey model with share encode/decode.
module tb_clm_mixcol_ark_serial;
   import clm_mixcol_ark_serial_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   state_mat_t in_state;
   state_mat_t in_key;
   logic       rand_valid;
   logic       rand_ready;
   rand_vect_t random_vect;
   mm_matrix_t L;
   bm_matrix_t B_ext_MC;
   mr_matrix_t MC;
   logic       out_valid;
   logic       out_ready;
   state_mat_t out_state;

   int checkCount = 0;
   int errorCount = 0;
   int randHandshakes = 0;

   always #5 clk = ~clk;

   clm_mixcol_ark_serial dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .in_key      (in_key),
      .rand_valid  (rand_valid),
      .rand_ready  (rand_ready),
      .random_vect (random_vect),
      .L           (L),
      .B_ext_MC    (B_ext_MC),
      .MC          (MC),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state)
   );

   always @(posedge clk) begin
      if (rst_n && rand_valid && rand_ready) randHandshakes++;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b);
      return {b[6:0], b[7]};
   endfunction

   function automatic logic [7:0] rotr8(input logic [7:0] b);
      return {b[0], b[7:1]};
   endfunction

   // AES MixColumns on a column written row 0 first (MSB).
   function automatic logic [31:0] mixWord(input logic [31:0] w);
      logic [7:0]  a [4];
      logic [31:0] o;
      for (int r = 0; r < 4; r++) a[r] = w[31-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
         o[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                          ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
      return o;
   endfunction

   // Same map on the matrix bit layout (row r at bits 8r+7..8r).
   function automatic logic [31:0] mixBits(input logic [31:0] v);
      logic [31:0] o;
      o = mixWord({v[7:0], v[15:8], v[23:16], v[31:24]});
      return {o[7:0], o[15:8], o[23:16], o[31:24]};
   endfunction

   function automatic logic [31:0] lBlk(input logic [31:0] v);
      logic [31:0] o;
      for (int r = 0; r < 4; r++) o[8*r +: 8] = rotl8(v[8*r +: 8]);
      return o;
   endfunction

   function automatic logic [31:0] linvBlk(input logic [31:0] v);
      logic [31:0] o;
      for (int r = 0; r < 4; r++) o[8*r +: 8] = rotr8(v[8*r +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] roundModel(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] res;
      for (int c = 0; c < 4; c++) res[127-32*c -: 32] = mixWord(pt[127-32*c -: 32]);
      return res ^ key;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic state_mat_t encodeState(input logic [127:0] x);
      state_mat_t s;
      logic [7:0] b, m1, m2, m3;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b  = x[127-8*(4*c+r) -: 8];
            m1 = 8'($urandom);
            m2 = 8'($urandom);
            m3 = 8'($urandom);
            s[c][r][1] = m1;
            s[c][r][2] = m2;
            s[c][r][3] = m3;
            s[c][r][0] = rotr8(b ^ m1 ^ m2 ^ m3);
         end
      end
      return s;
   endfunction

   function automatic logic [127:0] decodeState(input state_mat_t s);
      logic [127:0] x;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            x[127-8*(4*c+r) -: 8] = rotl8(s[c][r][0]) ^ s[c][r][1] ^ s[c][r][2] ^ s[c][r][3];
         end
      end
      return x;
   endfunction

   function automatic rand_vect_t randomRandVect();
      rand_vect_t v;
      for (int k = 0; k < 16; k++) v[k] = 8'($urandom);
      return v;
   endfunction

   task automatic buildMatrices();
      logic [31:0] e, m, bcol;
      logic [7:0]  eb, lb;
      for (int j = 0; j < 8; j++) begin
         eb = 8'd1 << j;
         lb = rotl8(eb);
         for (int i = 0; i < 8; i++) L[i][j] = lb[i];
      end
      for (int j = 0; j < 32; j++) begin
         e    = 32'd1 << j;
         m    = mixBits(e);
         bcol = linvBlk(mixBits(lBlk(e)));
         for (int i = 0; i < 32; i++) begin
            MC[i][j]       = m[i];
            B_ext_MC[i][j] = bcol[i];
         end
      end
   endtask

   // stallMode 0: rand_valid held high; 1: low on edges stallStart..stallStart+stallLen-1
   // (edge 1 is the first after acceptance); 2: random rand_valid plus junk on in_valid.
   task automatic applyStimulus(input state_mat_t encState, input state_mat_t encKey,
                                input int stallMode, input int stallStart, input int stallLen,
                                input int holdCycles, input string tag,
                                output state_mat_t rawOut, output int latency);
      int waitCnt;
      rawOut  = '0;
      latency = -1;
      waitCnt = 0;
      while (!in_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput({tag, " in_ready timeout"}, 0, 1);
         return;
      end
      in_state       = encState;
      in_key         = encKey;
      in_valid       = 1'b1;
      out_ready      = 1'b0;
      rand_valid     = 1'b0;
      randHandshakes = 0;
      @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 80; m++) begin
         if (out_valid) begin
            latency = m;
            break;
         end
         if (stallMode == 2) begin
            in_valid   = 1'b1;
            in_state   = encodeState(rand128());
            rand_valid = 1'($urandom_range(0, 1));
         end else begin
            in_valid   = 1'b0;
            rand_valid = (stallMode == 1 && (m+1) >= stallStart && (m+1) < stallStart + stallLen)
                         ? 1'b0 : 1'b1;
         end
         random_vect = randomRandVect();
         @(negedge clk);
      end
      in_valid   = 1'b0;
      rand_valid = 1'b0;
      if (latency < 0) begin
         checkOutput({tag, " out_valid timeout"}, 0, 1);
         return;
      end
      rawOut = out_state;
      checkOutput({tag, " rand handshakes"}, randHandshakes, 4);
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput({tag, " stable out_state"}, out_state, rawOut);
         checkOutput({tag, " hold out_valid"}, out_valid, 1);
         checkOutput({tag, " hold in_ready"}, in_ready, 0);
         checkOutput({tag, " hold rand_ready"}, rand_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, " in_ready after handoff"}, in_ready, 1);
      checkOutput({tag, " out_valid after handoff"}, out_valid, 0);
   endtask

   initial begin
      logic [127:0] pt, key, expOut;
      state_mat_t   raw1, raw2, encS, encK;
      int           lat;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      rand_valid  = 1'b0;
      in_state    = '0;
      in_key      = '0;
      random_vect = '0;
      buildMatrices();
      #12;
      checkOutput("reset in_ready", in_ready, 0);
      checkOutput("reset rand_ready", rand_ready, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_state", out_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle in_ready", in_ready, 1);

      // Single FIPS-197 column with zero key
      pt = {8'hdb, 8'h13, 8'h53, 8'h45, 96'h0};
      applyStimulus(encodeState(pt), encodeState(128'h0), 0, 0, 0, 0, "fips col", raw1, lat);
      checkOutput("fips col latency", lat, 4);
      expOut = decodeState(raw1);
      checkOutput("fips col0 value", expOut[127:96], 32'h8e4da1bc);
      checkOutput("fips col rest", expOut[95:0], 96'h0);

      // Appendix B round 1: after ShiftRows state plus round-1 key
      pt  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      key = 128'ha0fafe1788542cb123a339392a6c7605;
      applyStimulus(encodeState(pt), encodeState(key), 0, 0, 0, 0, "full round", raw1, lat);
      checkOutput("full round latency", lat, 4);
      checkOutput("full round value", decodeState(raw1), 128'ha49c7ff2689f352b6b5bea43026a5049);

      applyStimulus(encodeState(pt), encodeState(key), 1, 3, 3, 0, "rand stall", raw1, lat);
      checkOutput("rand stall latency", lat, 7);
      checkOutput("rand stall value", decodeState(raw1), 128'ha49c7ff2689f352b6b5bea43026a5049);

      pt  = rand128();
      key = rand128();
      applyStimulus(encodeState(pt), encodeState(key), 0, 0, 0, 5, "backpressure", raw1, lat);
      checkOutput("backpressure value", decodeState(raw1), roundModel(pt, key));

      // Reset after column 2 has been written
      pt          = rand128();
      key         = rand128();
      in_state    = encodeState(pt);
      in_key      = encodeState(key);
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
      rand_valid  = 1'b1;
      random_vect = randomRandVect();
      repeat (3) begin
         @(negedge clk);
         random_vect = randomRandVect();
      end
      rand_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun reset in_ready", in_ready, 0);
      checkOutput("midrun reset rand_ready", rand_ready, 0);
      checkOutput("midrun reset out_valid", out_valid, 0);
      checkOutput("midrun reset out_state", out_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pt  = rand128();
      key = rand128();
      applyStimulus(encodeState(pt), encodeState(key), 0, 0, 0, 0, "after reset", raw1, lat);
      checkOutput("after reset latency", lat, 4);
      checkOutput("after reset value", decodeState(raw1), roundModel(pt, key));

      // Same encoded input, two independent randomness streams
      pt   = rand128();
      key  = rand128();
      encS = encodeState(pt);
      encK = encodeState(key);
      applyStimulus(encS, encK, 0, 0, 0, 0, "mask run1", raw1, lat);
      applyStimulus(encS, encK, 0, 0, 0, 0, "mask run2", raw2, lat);
      checkOutput("mask raw differ", (raw1 != raw2), 1);
      checkOutput("mask run1 value", decodeState(raw1), roundModel(pt, key));
      checkOutput("mask run2 value", decodeState(raw2), roundModel(pt, key));

      for (int t = 0; t < 6; t++) begin
         pt  = rand128();
         key = rand128();
         applyStimulus(encodeState(pt), encodeState(key), 2, 0, 0,
                       int'($urandom_range(0, 2)), "random", raw1, lat);
         checkOutput("random value", decodeState(raw1), roundModel(pt, key));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/clm_mixcol_ark_serial.md
Name: clm_mixcol_ark_serial

Overview:
- Column-serial CLM-masked MixColumns + AddRoundKey round stage. Sits directly downstream of the masked ShiftRows output and upstream of the round-state register.
- Accepts a full masked state plus a masked round key. Pushes one column per cycle through a single mix_column_single instance, using 16 fresh red_poly_t randomness words per column. XORs in the masked round-key column and returns the full state.
- Trades 4x fewer MixColumns instances for multi-cycle latency.

Parameters:
- d, types::d, masking order; sets the widths of all state_t, red_poly_t and matrix types.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream state/key valid
- in_ready  out  1  stage can accept a new state
- in_state  in  4 x state_word_t  masked state, column-major, [c][r]
- in_key  in  4 x state_word_t  masked round key, same layout
- rand_valid  in  1  random_vect word set available
- rand_ready  out  1  stage consumes random_vect this cycle
- random_vect  in  16 x red_poly_t  fresh randomness for one column
- L  in  mm_matrix_t  encoding matrix; static
- B_ext_MC  in  bm_matrix_t  extension matrix; static
- MC  in  mr_matrix_t  reduction matrix; static
- out_valid  out  1  out_state valid
- out_ready  in  1  downstream accepts out_state
- out_state  out  4 x state_word_t  MixColumns(in_state) ^ in_key, masked

Behaviour:
- FSM states IDLE, RUN, DONE. rst_n low (async) forces IDLE, col_cnt=0, state/key/result regs=0. Outputs during reset: in_ready=0, rand_ready=0, out_valid=0, out_state=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state and in_key, col_cnt<=0, go to RUN.
- RUN:
  - rand_ready=1, in_ready=0.
  - mix_column_single input = state_reg[col_cnt], with random_vect passed straight through.
  - On rand_valid: result_reg[col_cnt] <= mix_out ^ key_reg[col_cnt], col_cnt++.
  - rand_valid=0 stalls: no state change and no randomness consumed.
  - After column 3 is written, col_cnt wraps to 0 and the FSM goes to DONE.
- DONE:
  - out_valid=1, out_state=result_reg, rand_ready=0, in_ready=0.
  - On out_ready: go to IDLE.
  - out_state stays stable while out_valid && !out_ready.
- out_state is driven from result_reg at all times. It is meaningful only when out_valid=1.
- Latency with rand_valid held high: accept at edge k, columns at edges k+1..k+4, out_valid high after edge k+4. Minimum 4 cycles; throughput 1 state per 6 cycles (accept, 4 columns, handoff).
- Randomness is used exactly once. Each accepted random_vect set goes to exactly one column, and no set is reused across columns or states.
- in_valid while not IDLE: ignored, because in_ready=0. Upstream must hold it.
- Reset asserted mid-RUN or mid-DONE: immediate abort, partial result discarded, out_valid drops asynchronously.
- L, B_ext_MC and MC must stay constant while the FSM is outside IDLE. They are not registered.
- All XORs are on full masked state_t/red_poly_t widths. No unmasking happens inside the block.

Decomposition:
- In the types package:
  - new state_mat_t, defined as state_word_t[0:3];
  - fsm enum mcark_state_t {IDLE, RUN, DONE};
  - NUM_COLS=4.
- Sub-module: existing mix_column_single, one instance.
- Keep the FSM and column mux inline. No further sub-modules.

Test Plan:
- FIPS-197 column: encode column 0 as db,13,53,45, key 0, rand_valid held 1. After 4 RUN edges, out_valid=1 and column 0 decodes to 8e,4d,a1,bc.
- Full round: encode FIPS-197 Appendix B round-1 after-ShiftRows state and the round-1 key. Decoded out_state must equal the round-2 start state (a4 9c 7f f2 ...). out_valid must rise exactly 4 cycles after acceptance.
- Randomness stall: deassert rand_valid for 3 cycles after column 1. col_cnt must hold, out_valid must rise 7 cycles after acceptance, and decoded result must be unchanged. Count exactly 4 rand handshakes.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_state must stay stable, in_ready=0 and rand_ready=0. Pulse out_ready: in_ready=1 on the next cycle.
- Reset mid-RUN: drop rst_n after column 2. Outputs must clear immediately. After release, a fresh state must produce the correct result with no stale columns.
- Mask independence: same plaintext with two different random_vect streams. Raw out_state must differ, and the decoded outputs must be identical.
